// File: rtl/led_seq_pkg.sv
// Shared types for the LED pattern sequencer: display modes, FSM states and mode decode.
package led_seq_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        OFF    = 3'd0,
        BLINK  = 3'd1,
        CHASE  = 3'd2,
        BOUNCE = 3'd3,
        COUNT  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } fsm_e;

    // Unknown encodings fall back to OFF so the LEDs go dark rather than misbehave.
    function automatic mode_e decode_mode(input logic [MODE_W-1:0] m);
        return (m > MODE_W'(COUNT)) ? OFF : mode_e'(m);
    endfunction

endpackage

// File: rtl/led_pattern_seq_if.sv
// Mode command handshake between the user-control logic and the LED sequencer.
interface led_pattern_seq_if;
    import led_seq_pkg::*;

    logic              cmd_valid;
    logic [MODE_W-1:0] cmd_mode;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd_mode, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_mode, output cmd_ready);

endinterface

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing one tick every TICK_DIV enabled cycles.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 30_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned      CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Counter freezes whenever en is low so the step phase survives a pause.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// Steps an LED bank through selectable patterns once per prescaled tick,
// with a one-deep mode command slot applied on the next tick.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = 30_000_000,
    parameter int unsigned N_LEDS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    led_pattern_seq_if.slave   cmd,
    input  logic               pause,
    output logic [N_LEDS-1:0]  leds,
    output logic               wrap,
    output mode_e              cur_mode
);

    localparam logic [N_LEDS-1:0] ONES = '1;
    localparam logic [N_LEDS-1:0] ONE  = N_LEDS'(1);

    logic              tick;
    logic              ready_q;
    logic              dir_up_q;
    mode_e             pend_mode_q;
    fsm_e              fsm_c;

    logic [N_LEDS-1:0] leds_nxt;
    logic              wrap_nxt;
    logic              dir_nxt;
    logic              ready_nxt;
    mode_e             cur_nxt;
    mode_e             pend_nxt;

    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (!pause),
        .tick (tick)
    );

    assign cmd.cmd_ready = ready_q;

    // Operating state follows the displayed mode and the pause level every cycle.
    always_comb begin
        fsm_c = IDLE;
        if (cur_mode != OFF) begin
            fsm_c = pause ? HOLD : RUN;
        end
    end

    always_comb begin
        leds_nxt  = leds;
        wrap_nxt  = 1'b0;
        dir_nxt   = dir_up_q;
        cur_nxt   = cur_mode;
        ready_nxt = ready_q;
        pend_nxt  = pend_mode_q;

        if (cmd.cmd_valid && ready_q) begin
            ready_nxt = 1'b0;
            pend_nxt  = decode_mode(cmd.cmd_mode);
        end

        // A pending command takes the tick instead of a pattern step.
        if (tick && !ready_q) begin
            cur_nxt   = pend_mode_q;
            ready_nxt = 1'b1;
            dir_nxt   = 1'b1;
            case (pend_mode_q)
                BLINK:   leds_nxt = ONES;
                CHASE:   leds_nxt = ONE;
                BOUNCE:  leds_nxt = ONE;
                default: leds_nxt = '0;
            endcase
        end else if (tick && fsm_c == RUN) begin
            case (cur_mode)
                BLINK: begin
                    leds_nxt = (leds == '0) ? ONES : '0;
                    wrap_nxt = (leds == '0);
                end
                CHASE: begin
                    leds_nxt = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
                    wrap_nxt = leds[N_LEDS-1];
                end
                BOUNCE: begin
                    if (dir_up_q) begin
                        leds_nxt = leds << 1;
                        dir_nxt  = !leds[N_LEDS-2];
                    end else begin
                        leds_nxt = leds >> 1;
                        dir_nxt  = leds[1];
                        wrap_nxt = leds[1];
                    end
                end
                COUNT: begin
                    leds_nxt = leds + ONE;
                    wrap_nxt = (leds == ONES);
                end
                default: leds_nxt = '0;
            endcase
        end

        if (cur_nxt == OFF) begin
            leds_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds        <= '0;
            wrap        <= 1'b0;
            cur_mode    <= OFF;
            ready_q     <= 1'b1;
            pend_mode_q <= OFF;
            dir_up_q    <= 1'b1;
        end else begin
            leds        <= leds_nxt;
            wrap        <= wrap_nxt;
            cur_mode    <= cur_nxt;
            ready_q     <= ready_nxt;
            pend_mode_q <= pend_nxt;
            dir_up_q    <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq: vector table, directed corner sequences and random traffic vs a step-index model.
module tb_led_pattern_seq;
    import led_seq_pkg::*;

    localparam int TD  = 4;
    localparam int NL  = 4;
    localparam int NL3 = 3;
    localparam int NV  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           pause4, pause3;
    logic [NL-1:0]  leds4;
    logic [NL3-1:0] leds3;
    logic           wrap4, wrap3;
    mode_e          mode4, mode3;

    led_pattern_seq_if if4();
    led_pattern_seq_if if3();

    led_pattern_seq #(.TICK_DIV(TD), .N_LEDS(NL)) u_dut4 (
        .clk(clk), .rst(rst), .cmd(if4.slave), .pause(pause4),
        .leds(leds4), .wrap(wrap4), .cur_mode(mode4)
    );

    led_pattern_seq #(.TICK_DIV(TD), .N_LEDS(NL3)) u_dut3 (
        .clk(clk), .rst(rst), .cmd(if3.slave), .pause(pause3),
        .leds(leds3), .wrap(wrap3), .cur_mode(mode3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode plus position k within the pattern period.
    int m_cnt, m_k, m_mode, m_pmode;
    bit m_pend, m_wrap;

    typedef struct {
        int         n;
        bit         r;
        bit         v;
        logic [2:0] md;
        bit         p;
        int         e_leds;
        bit         e_wrap;
        bit         e_ready;
        int         e_mode;
    } vec_t;

    vec_t tbl [NV];

    function automatic int period(input int m);
        case (m)
            1:       return 2;
            2:       return NL;
            3:       return 2 * (NL - 1);
            4:       return 1 << NL;
            default: return 1;
        endcase
    endfunction

    function automatic int pat(input int m, input int k);
        case (m)
            1:       return (k == 0) ? (1 << NL) - 1 : 0;
            2:       return 1 << k;
            3:       return (k < NL) ? (1 << k) : (1 << (2 * (NL - 1) - k));
            4:       return k;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit tk, acc;
        if (rst) begin
            m_cnt = 0; m_mode = 0; m_pmode = 0; m_pend = 0; m_k = 0; m_wrap = 0;
        end else begin
            tk  = (m_cnt == TD - 1) && !pause4;
            acc = if4.cmd_valid && !m_pend;
            if (!pause4) m_cnt = (m_cnt + 1) % TD;
            m_wrap = 0;
            if (tk && m_pend) begin
                m_mode = m_pmode; m_pend = 0; m_k = 0;
            end else if (tk && m_mode != 0) begin
                m_k    = (m_k + 1) % period(m_mode);
                m_wrap = (m_k == 0);
            end
            if (acc) begin
                m_pend  = 1;
                m_pmode = (int'(if4.cmd_mode) > 4) ? 0 : int'(if4.cmd_mode);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_leds",  32'(leds4),          32'(pat(m_mode, m_k)));
        chk("model_wrap",  32'(wrap4),          32'(m_wrap));
        chk("model_mode",  32'(mode4),          32'(m_mode));
        chk("model_ready", 32'(if4.cmd_ready),  32'(!m_pend));
    endtask

    task automatic wait_leds(input bit on3, input int exp, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            cycle();
            hit = on3 ? (int'(leds3) == exp) : (int'(leds4) == exp);
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL wait_leds: leds never reached %0h within %0d cycles", exp, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bval [7];
        rst = 1'b1; pause4 = 1'b0; pause3 = 1'b0;
        if4.cmd_valid = 1'b0; if4.cmd_mode = 3'd0;
        if3.cmd_valid = 1'b0; if3.cmd_mode = 3'd0;

        // Reset, idle, then a full CHASE period.
        tbl[0] = '{3,  1'b1, 1'b0, 3'd0, 1'b0, 0, 1'b0, 1'b1, 0};
        tbl[1] = '{20, 1'b0, 1'b0, 3'd0, 1'b0, 0, 1'b0, 1'b1, 0};
        tbl[2] = '{1,  1'b0, 1'b1, 3'd2, 1'b0, 0, 1'b0, 1'b0, 0};
        tbl[3] = '{3,  1'b0, 1'b0, 3'd0, 1'b0, 1, 1'b0, 1'b1, 2};
        tbl[4] = '{4,  1'b0, 1'b0, 3'd0, 1'b0, 2, 1'b0, 1'b1, 2};
        tbl[5] = '{4,  1'b0, 1'b0, 3'd0, 1'b0, 4, 1'b0, 1'b1, 2};
        tbl[6] = '{4,  1'b0, 1'b0, 3'd0, 1'b0, 8, 1'b0, 1'b1, 2};
        tbl[7] = '{3,  1'b0, 1'b0, 3'd0, 1'b0, 8, 1'b0, 1'b1, 2};
        tbl[8] = '{1,  1'b0, 1'b0, 3'd0, 1'b0, 1, 1'b1, 1'b1, 2};
        tbl[9] = '{1,  1'b0, 1'b0, 3'd0, 1'b0, 1, 1'b0, 1'b1, 2};

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].r; if4.cmd_valid = tbl[i].v; if4.cmd_mode = tbl[i].md; pause4 = tbl[i].p;
            repeat (tbl[i].n) cycle();
            chk("tbl_leds",  32'(leds4),         32'(tbl[i].e_leds));
            chk("tbl_wrap",  32'(wrap4),         32'(tbl[i].e_wrap));
            chk("tbl_ready", 32'(if4.cmd_ready), 32'(tbl[i].e_ready));
            chk("tbl_mode",  32'(mode4),         32'(tbl[i].e_mode));
        end

        // BOUNCE: one full period of six steps after the start value.
        bval = '{1, 2, 4, 8, 4, 2, 1};
        if4.cmd_valid = 1'b1; if4.cmd_mode = 3'd3;
        cycle();
        if4.cmd_valid = 1'b0;
        cycle();
        for (int i = 0; i < 7; i++) begin
            cycle();
            chk("bounce_leds", 32'(leds4), 32'(bval[i]));
            chk("bounce_wrap", 32'(wrap4), 32'(i == 6));
            chk("bounce_mode", 32'(mode4), 32'(3));
            repeat (3) cycle();
        end

        // COUNT sent on a tick cycle, then paused at 0101.
        if4.cmd_valid = 1'b1; if4.cmd_mode = 3'd4;
        cycle();
        if4.cmd_valid = 1'b0;
        wait_leds(1'b0, 5, 200);
        cycle();
        pause4 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("pause_hold", 32'(leds4), 32'(5));
        end
        pause4 = 1'b0;
        cycle(); chk("pause_rel1", 32'(leds4), 32'(5));
        cycle(); chk("pause_rel2", 32'(leds4), 32'(5));
        cycle(); chk("pause_step", 32'(leds4), 32'(6));
        chk("pause_wrap", 32'(wrap4), 32'(0));

        // Three-LED COUNT wrap with BLINK issued on the tick cycle.
        rst = 1'b1; cycle(); rst = 1'b0;
        if3.cmd_valid = 1'b1; if3.cmd_mode = 3'd4;
        cycle();
        if3.cmd_valid = 1'b0;
        wait_leds(1'b1, 7, 100);
        repeat (3) cycle();
        if3.cmd_valid = 1'b1; if3.cmd_mode = 3'd1;
        cycle();
        chk("n3_wrap_leds",  32'(leds3),         32'(0));
        chk("n3_wrap_pulse", 32'(wrap3),         32'(1));
        chk("n3_ready_lo",   32'(if3.cmd_ready), 32'(0));
        chk("n3_mode_cnt",   32'(mode3),         32'(4));
        if3.cmd_mode = 3'd2;
        cycle();
        chk("n3_ignored_rdy", 32'(if3.cmd_ready), 32'(0));
        if3.cmd_valid = 1'b0;
        repeat (2) cycle();
        cycle();
        chk("n3_blink_start", 32'(leds3),         32'(7));
        chk("n3_blink_mode",  32'(mode3),         32'(1));
        chk("n3_blink_rdy",   32'(if3.cmd_ready), 32'(1));
        chk("n3_apply_wrap",  32'(wrap3),         32'(0));
        repeat (4) cycle();
        chk("n3_blink_off",   32'(leds3), 32'(0));
        chk("n3_blink_nowr",  32'(wrap3), 32'(0));
        repeat (4) cycle();
        chk("n3_blink_on",    32'(leds3), 32'(7));
        chk("n3_blink_wrap",  32'(wrap3), 32'(1));
        chk("n3_still_blink", 32'(mode3), 32'(1));

        // Reset mid-BOUNCE with CHASE pending, then an out-of-range mode.
        if4.cmd_valid = 1'b1; if4.cmd_mode = 3'd3;
        cycle();
        if4.cmd_valid = 1'b0;
        wait_leds(1'b0, 4, 100);
        if4.cmd_valid = 1'b1; if4.cmd_mode = 3'd2;
        cycle();
        chk("rst_pend_rdy", 32'(if4.cmd_ready), 32'(0));
        if4.cmd_valid = 1'b0;
        rst = 1'b1;
        cycle();
        chk("rst_leds",  32'(leds4),         32'(0));
        chk("rst_mode",  32'(mode4),         32'(0));
        chk("rst_ready", 32'(if4.cmd_ready), 32'(1));
        chk("rst_wrap",  32'(wrap4),         32'(0));
        rst = 1'b0;
        if4.cmd_valid = 1'b1; if4.cmd_mode = 3'd7;
        cycle();
        chk("bad_mode_acc", 32'(if4.cmd_ready), 32'(0));
        if4.cmd_valid = 1'b0;
        repeat (3) cycle();
        chk("bad_mode_off", 32'(mode4),         32'(0));
        chk("bad_mode_rdy", 32'(if4.cmd_ready), 32'(1));
        repeat (8) cycle();
        chk("discard_mode", 32'(mode4), 32'(0));
        chk("discard_leds", 32'(leds4), 32'(0));

        // Random commands, pauses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(299) == 0);
            if4.cmd_valid = ($urandom_range(3) == 0);
            if4.cmd_mode  = 3'($urandom_range(7));
            pause4        = ($urandom_range(4) == 0);
            cycle();
        end
        rst = 1'b0; if4.cmd_valid = 1'b0; pause4 = 1'b0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
